// File: rtl/flash_qspi_rd_arbiter.sv
// flash_qspi_rd_arbiter: two-port 32-bit word reader for a quad-SPI flash
// using Fast Read Quad I/O (0xEB). Macro FLASH_ARB_RR_EN selects round-robin.
module flash_qspi_rd_arbiter #(
    parameter int         ADDR_W       = 24,
    parameter int         DUMMY_CLKS   = 4,
    parameter logic [7:0] MODE_BYTE    = 8'hFF,
    parameter int         CS_HIGH_CLKS = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              fsclk,
    output logic              fcen,
    output logic [3:0]        fdo,
    output logic              fdoe,
    input  logic [3:0]        fdi
);

    localparam int CNT_MAX = (DUMMY_CLKS > 8) ? DUMMY_CLKS : 8;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [7:0]    CMD_QIOR = 8'hEB;
    localparam logic [3:0]    FDO_IDLE = 4'b1100;
    localparam logic [CW-1:0] L_CMD    = CW'(7);
    localparam logic [CW-1:0] L_ADDR   = CW'(ADDR_W / 4 - 1);
    localparam logic [CW-1:0] L_MODE   = CW'(1);
    localparam logic [CW-1:0] L_DUMMY  = CW'(DUMMY_CLKS - 1);
    localparam logic [CW-1:0] L_DATA   = CW'(7);
    localparam logic [CW-1:0] L_RECOV  = CW'(CS_HIGH_CLKS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_RECOV
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_n;
    logic              r_fsclk;
    logic              w_fsclk_n;
    logic              r_fcen;
    logic              w_fcen_n;
    logic [3:0]        r_fdo;
    logic [3:0]        w_fdo_n;
    logic              r_fdoe;
    logic              w_fdoe_n;
    logic              r_tail;
    logic              w_tail_n;
    logic              r_port;
    logic              w_port_n;
    logic [ADDR_W-1:0] r_ash;
    logic [ADDR_W-1:0] w_ash_n;
    logic [7:0]        r_cmd;
    logic [7:0]        w_cmd_n;
    logic [31:0]       r_rx;
    logic [31:0]       w_rx_n;
    logic [31:0]       r_rdata;
    logic [31:0]       w_rdata_n;
    logic              r_rv0;
    logic              w_rv0_n;
    logic              r_rv1;
    logic              w_rv1_n;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr_sel;

`ifdef FLASH_ARB_RR_EN
    logic              r_prio;

    // Priority pointer: the port that did not win the last grant goes first.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_prio <= 1'b0;
        end else if (w_gnt0 | w_gnt1) begin
            r_prio <= w_gnt0;
        end
    end

    // Grant decision, only while idle and out of reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == S_IDLE && !wb_rst_i) begin
            if (req0 && req1) begin
                w_gnt0 = ~r_prio;
                w_gnt1 = r_prio;
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end
`else
    // Grant decision, only while idle and out of reset; port 0 wins ties.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == S_IDLE && !wb_rst_i) begin
            w_gnt0 = req0;
            w_gnt1 = req1 & ~req0;
        end
    end
`endif

    assign w_addr_sel = w_gnt1 ? addr1 : addr0;

    // Last SCLK (or recovery cycle) of the current state.
    always_comb begin
        w_last = 1'b0;
        unique case (r_state)
            S_CMD:   w_last = (r_cnt == L_CMD);
            S_ADDR:  w_last = (r_cnt == L_ADDR);
            S_MODE:  w_last = (r_cnt == L_MODE);
            S_DUMMY: w_last = (r_cnt == L_DUMMY);
            S_DATA:  w_last = (r_cnt == L_DATA);
            S_RECOV: w_last = (r_cnt == L_RECOV);
            default: w_last = 1'b0;
        endcase
    end

    // Next-state and pin/shifter updates; one SCLK is a low then a high HCLK.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_fsclk_n = r_fsclk;
        w_fcen_n  = r_fcen;
        w_fdo_n   = r_fdo;
        w_fdoe_n  = r_fdoe;
        w_tail_n  = r_tail;
        w_port_n  = r_port;
        w_ash_n   = r_ash;
        w_cmd_n   = r_cmd;
        w_rx_n    = r_rx;
        w_rdata_n = r_rdata;
        w_rv0_n   = 1'b0;
        w_rv1_n   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_fcen_n  = 1'b1;
                w_fsclk_n = 1'b0;
                w_fdoe_n  = 1'b0;
                w_fdo_n   = FDO_IDLE;
                if (w_gnt0 | w_gnt1) begin
                    w_state_n = S_CMD;
                    w_cnt_n   = '0;
                    w_fcen_n  = 1'b0;
                    w_fdoe_n  = 1'b1;
                    w_port_n  = w_gnt1;
                    w_ash_n   = w_addr_sel & WORD_MASK;
                    w_cmd_n   = {CMD_QIOR[6:0], 1'b0};
                    w_fdo_n   = {3'b110, CMD_QIOR[7]};
                end
            end
            S_RECOV: begin
                if (w_last) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CNT_ONE;
                end
            end
            default: begin
                if (r_tail) begin
                    w_tail_n  = 1'b0;
                    w_state_n = S_RECOV;
                    w_cnt_n   = '0;
                    w_fcen_n  = 1'b1;
                    w_rdata_n = {r_rx[7:0], r_rx[15:8],
                                 r_rx[23:16], r_rx[31:24]};
                    w_rv0_n   = ~r_port;
                    w_rv1_n   = r_port;
                end else if (!r_fsclk) begin
                    w_fsclk_n = 1'b1;
                    if (r_state == S_DATA) begin
                        w_rx_n = {r_rx[27:0], fdi};
                    end
                end else begin
                    w_fsclk_n = 1'b0;
                    if (w_last) begin
                        w_cnt_n = '0;
                        unique case (r_state)
                            S_CMD: begin
                                w_state_n = S_ADDR;
                                w_fdo_n   = r_ash[ADDR_W-1 -: 4];
                                w_ash_n   = {r_ash[ADDR_W-5:0], 4'b0000};
                            end
                            S_ADDR: begin
                                w_state_n = S_MODE;
                                w_fdo_n   = MODE_BYTE[7:4];
                            end
                            S_MODE: begin
                                w_state_n = S_DUMMY;
                                w_fdoe_n  = 1'b0;
                                w_fdo_n   = FDO_IDLE;
                            end
                            S_DUMMY: w_state_n = S_DATA;
                            S_DATA:  w_tail_n = 1'b1;
                            default: w_state_n = S_IDLE;
                        endcase
                    end else begin
                        w_cnt_n = r_cnt + CNT_ONE;
                        unique case (r_state)
                            S_CMD: begin
                                w_fdo_n = {3'b110, r_cmd[7]};
                                w_cmd_n = {r_cmd[6:0], 1'b0};
                            end
                            S_ADDR: begin
                                w_fdo_n = r_ash[ADDR_W-1 -: 4];
                                w_ash_n = {r_ash[ADDR_W-5:0], 4'b0000};
                            end
                            S_MODE:  w_fdo_n = MODE_BYTE[3:0];
                            default: w_fdo_n = r_fdo;
                        endcase
                    end
                end
            end
        endcase
    end

    // State register and all registered flash pins and read outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fsclk <= 1'b0;
            r_fcen  <= 1'b1;
            r_fdo   <= FDO_IDLE;
            r_fdoe  <= 1'b0;
            r_tail  <= 1'b0;
            r_port  <= 1'b0;
            r_ash   <= '0;
            r_cmd   <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_fsclk <= w_fsclk_n;
            r_fcen  <= w_fcen_n;
            r_fdo   <= w_fdo_n;
            r_fdoe  <= w_fdoe_n;
            r_tail  <= w_tail_n;
            r_port  <= w_port_n;
            r_ash   <= w_ash_n;
            r_cmd   <= w_cmd_n;
            r_rx    <= w_rx_n;
            r_rdata <= w_rdata_n;
            r_rv0   <= w_rv0_n;
            r_rv1   <= w_rv1_n;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rv0;
    assign rvalid1 = r_rv1;
    assign rdata   = r_rdata;
    assign busy    = (r_state != S_IDLE) | w_gnt0 | w_gnt1;
    assign fsclk   = r_fsclk;
    assign fcen    = r_fcen;
    assign fdo     = r_fdo;
    assign fdoe    = r_fdoe;

endmodule

// File: tb/tb_flash_qspi_rd_arbiter.sv
// Bench for flash_qspi_rd_arbiter: behavioural flash on the pins plus an
// arbitration/timing reference model; randomized addresses and requests.
`timescale 1ns/1ps
module tb_flash_qspi_rd_arbiter;

    localparam int DUMMY = 4;
    localparam int NEDGE = 8 + 6 + 2 + DUMMY + 8;
    localparam int LAT   = 2 * NEDGE + 2;
    localparam int GAP   = LAT + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [23:0] addr0 = '0;
    logic [23:0] addr1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [31:0] rdata;
    logic        fsclk, fcen, fdoe;
    logic [3:0]  fdo;
    logic [3:0]  fdi = 4'hF;

    flash_qspi_rd_arbiter #(
        .ADDR_W(24),
        .DUMMY_CLKS(DUMMY),
        .MODE_BYTE(8'hFF),
        .CS_HIGH_CLKS(2)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .req0(req0),
        .addr0(addr0),
        .gnt0(gnt0),
        .rvalid0(rvalid0),
        .req1(req1),
        .addr1(addr1),
        .gnt1(gnt1),
        .rvalid1(rvalid1),
        .rdata(rdata),
        .busy(busy),
        .fsclk(fsclk),
        .fcen(fcen),
        .fdo(fdo),
        .fdoe(fdoe),
        .fdi(fdi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int rr_prio = 0;

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        int          edges;
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [7:0]  mode;
        int          oebad;
    } tx_t;

    ev_t gq[$];
    ev_t rq[$];
    tx_t txq[$];

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [23:0] b;
        b = a & ~24'h3;
        return {fbyte(b + 24'd3), fbyte(b + 24'd2), fbyte(b + 24'd1), fbyte(b)};
    endfunction

    function automatic int arb(input bit r0, input bit r1);
        int p;
`ifdef FLASH_ARB_RR_EN
        if (r0 && r1) p = rr_prio;
        else p = r1 ? 1 : 0;
`else
        p = r0 ? 0 : 1;
`endif
        rr_prio = (p == 0) ? 1 : 0;
        return p;
    endfunction

    // Behavioural flash: counts SCLK edges per chip-select, decodes the
    // command/address/mode, and drives data nibbles while SCLK is low.
    int          e = 0;
    logic [7:0]  m_cmd = '0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_mode = '0;
    int          m_oebad = 0;
    always @(posedge fsclk or negedge fsclk or posedge fcen) begin
        int k;
        logic [7:0] bt;
        if (fcen === 1'b1) begin
            if (e > 0) txq.push_back('{e, m_cmd, m_addr, m_mode, m_oebad});
            e = 0;
            m_oebad = 0;
        end else if (fsclk) begin
            e = e + 1;
            if (e <= 8) m_cmd = {m_cmd[6:0], fdo[0]};
            else if (e <= 14) m_addr = {m_addr[19:0], fdo};
            else if (e <= 16) m_mode = {m_mode[3:0], fdo};
            if ((e <= 16) != (fdoe === 1'b1)) m_oebad++;
        end else begin
            if (e >= 16 && fdoe !== 1'b0) m_oebad++;
            k = e + 1 - (17 + DUMMY);
            if (k >= 0 && k < 8) begin
                bt = fbyte(m_addr + 24'(k / 2));
                fdi = (k % 2 == 0) ? bt[7:4] : bt[3:0];
            end
        end
    end

    // Event recorder and pin-protocol watch, sampled mid-cycle.
    int   pin_bad = 0;
    int   hi_run = 100;
    logic p_fsclk = 1'b0;
    logic p_fcen = 1'b1;
    logic p_fdoe = 1'b0;
    logic [3:0] p_fdo = 4'h0;
    always @(negedge clk) begin
        if (gnt0) gq.push_back('{cyc, 0, 32'h0});
        if (gnt1) gq.push_back('{cyc, 1, 32'h0});
        if (rvalid0) rq.push_back('{cyc, 0, rdata});
        if (rvalid1) rq.push_back('{cyc, 1, rdata});
        if (gnt0 && gnt1) pin_bad++;
        if (rvalid0 && rvalid1) pin_bad++;
        if (fsclk === 1'b1 && p_fsclk === 1'b0 &&
            (fdo !== p_fdo || fdoe !== p_fdoe)) pin_bad++;
        if (fcen === 1'b0 && p_fcen === 1'b1 && hi_run < 2) pin_bad++;
        hi_run = (fcen === 1'b1) ? hi_run + 1 : 0;
        p_fsclk = fsclk;
        p_fcen = fcen;
        p_fdoe = fdoe;
        p_fdo = fdo;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output ev_t g);
        for (int i = 0; i < 200 && gq.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("gnt_seen", gq.size() != 0, 1);
        if (gq.size() != 0) g = gq.pop_front();
        else g = '{-1000, -1, 32'h0};
    endtask

    task automatic check_done(input int port, input int tg,
                              input logic [23:0] a);
        ev_t r;
        tx_t t;
        for (int i = 0; i < LAT + 20 && rq.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rvalid_seen", rq.size() != 0, 1);
        if (rq.size() != 0) begin
            r = rq.pop_front();
            chk("rvalid_port", r.port, port);
            chk("rvalid_latency", r.cyc - tg, LAT);
            chk("rdata", r.data, exp_word(a));
        end
        chk("flash_tx_seen", txq.size() != 0, 1);
        if (txq.size() != 0) begin
            t = txq.pop_front();
            chk("sclk_edges", t.edges, NEDGE);
            chk("cmd_byte", t.cmd, 8'hEB);
            chk("flash_addr", t.addr, a & ~24'h3);
            chk("mode_byte", t.mode, 8'hFF);
            chk("fdoe_phases", t.oebad, 0);
        end
    endtask

    initial begin
        ev_t g;
        ev_t g2;
        ev_t gs[4];
        int  p;
        int  t0;
        int  r;
        logic [23:0] a0;
        logic [23:0] a1;

        // Reset with a pending request: no grant may leak out.
        rst = 1'b1;
        req0 = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst_fcen", fcen, 1'b1);
        chk("rst_fsclk", fsclk, 1'b0);
        chk("rst_fdoe", fdoe, 1'b0);
        chk("rst_fdo", fdo, 4'b1100);
        chk("rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0 = 1'b0;
        rr_prio = 0;
        tick(2);
        gq.delete();
        txq.delete();

        // Single read of the word holding bytes 11 22 33 44.
        req0 = 1'b1;
        addr0 = 24'h000103;
        t0 = cyc;
        wait_gnt(g);
        p = arb(1'b1, 1'b0);
        chk("single_gnt_port", g.port, p);
        chk("single_gnt_cycle", g.cyc, t0);
        @(negedge clk);
        chk("t1_fcen", fcen, 1'b0);
        chk("t1_fsclk", fsclk, 1'b0);
        chk("t1_fdo", {fdoe, fdo}, 5'b11101);
        chk("t1_busy", busy, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        chk("t2_fsclk", fsclk, 1'b1);
        check_done(g.port, g.cyc, 24'h000103);
        chk("single_rdata_word", exp_word(24'h000103) == rdata, 1);

        // Contention: both rise together; loser is served after recovery.
        tick(3);
        a0 = 24'($urandom);
        a1 = 24'($urandom);
        addr0 = a0;
        addr1 = a1;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_gnt(g);
        p = arb(1'b1, 1'b1);
        chk("cont_first_port", g.port, p);
        @(posedge clk);
        #1;
        if (g.port == 0) req0 = 1'b0;
        else req1 = 1'b0;
        wait_gnt(g2);
        p = arb(req0, req1);
        chk("cont_second_port", g2.port, p);
        chk("cont_gap", g2.cyc - g.cyc, GAP);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        check_done(g.port, g.cyc, (g.port == 1) ? a1 : a0);
        check_done(g2.port, g2.cyc, (g2.port == 1) ? a1 : a0);

        // Four back-to-back grants with both requests held high.
        tick(3);
        a0 = 24'($urandom);
        a1 = 24'($urandom);
        addr0 = a0;
        addr1 = a1;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(gs[i]);
            p = arb(1'b1, 1'b1);
            chk("b2b_port", gs[i].port, p);
            if (i > 0) chk("b2b_gap", gs[i].cyc - gs[i-1].cyc, GAP);
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_done(gs[i].port, gs[i].cyc, (gs[i].port == 1) ? a1 : a0);
        end

        // Random request patterns; a loser that drops out is ignored.
        for (int rd = 0; rd < 6; rd++) begin
            tick(1 + $urandom_range(0, 3));
            r = $urandom_range(1, 3);
            a0 = 24'($urandom);
            a1 = 24'($urandom);
            addr0 = a0;
            addr1 = a1;
            req0 = r[0];
            req1 = r[1];
            wait_gnt(g);
            p = arb(r[0], r[1]);
            chk("rand_port", g.port, p);
            @(posedge clk);
            #1;
            req0 = 1'b0;
            req1 = 1'b0;
            check_done(g.port, g.cyc, (g.port == 1) ? a1 : a0);
            tick(4);
            chk("rand_no_stray_gnt", gq.size(), 0);
        end

        // Reset in the middle of the data phase.
        tick(2);
        addr0 = 24'($urandom);
        req0 = 1'b1;
        wait_gnt(g);
        p = arb(1'b1, 1'b0);
        chk("abort_gnt_port", g.port, p);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        for (int i = 0; i < 100 && cyc < g.cyc + 50; i++) tick(1);
        rst = 1'b1;
        #1;
        chk("abort_fcen", fcen, 1'b1);
        chk("abort_fsclk", fsclk, 1'b0);
        chk("abort_fdoe", fdoe, 1'b0);
        chk("abort_busy", busy, 1'b0);
        rr_prio = 0;
        tick(2);
        rst = 1'b0;
        tick(LAT + 5);
        chk("abort_no_rvalid", rq.size(), 0);
        chk("abort_tx_seen", txq.size(), 1);
        if (txq.size() != 0) chk("abort_edges", txq.pop_front().edges, 25);

        // Fresh read after reset release completes normally.
        a0 = 24'($urandom);
        addr0 = a0;
        req0 = 1'b1;
        wait_gnt(g);
        p = arb(1'b1, 1'b0);
        chk("post_rst_port", g.port, p);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        check_done(g.port, g.cyc, a0);

        tick(5);
        chk("pin_protocol", pin_bad, 0);
        chk("leftover_gnt", gq.size(), 0);
        chk("leftover_rvalid", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flash_qspi_rd_arbiter.md
Name: flash_qspi_rd_arbiter

Overview:
- Read-only quad-SPI flash controller for the SoC program flash (SST26WF080B-class part).
- Arbitrates 32-bit word reads between two requesters: port 0, instruction fetch, and port 1, data/AHB.
- Sequences one quad I/O read (0xEB) per grant.
- Drives the flash pins fsclk, fcen, fdo[3:0], fdoe and samples fdi[3:0].

Parameters:
- ADDR_W, 24, byte-address width presented to the flash.
- DUMMY_CLKS, 4, dummy SCLK cycles between the mode byte and data.
- MODE_BYTE, 8'hFF, mode bits sent after the address; 0xFF disables continuous-read.
- CS_HIGH_CLKS, 2, minimum HCLK cycles fcen stays high between transactions.

Ports:
- wb_clk_i  in  1  system clock (HCLK domain).
- wb_rst_i  in  1  asynchronous, active-high reset.
- req0  in  1  port-0 read request; held until gnt0.
- addr0  in  ADDR_W  port-0 byte address; stable while req0 is high.
- gnt0  out  1  one-cycle grant pulse for port 0.
- rvalid0  out  1  one-cycle pulse; rdata valid for port 0.
- req1, addr1, gnt1, rvalid1: same semantics as port 0, for port 1.
- rdata  out  32  read word, shared by both ports; qualify with rvalidN.
- busy  out  1  high from grant until the CS-high recovery ends.
- fsclk  out  1  flash serial clock.
- fcen  out  1  flash chip enable, active low.
- fdo  out  4  flash SIO output data.
- fdoe  out  1  flash SIO output enable, common to all 4 lines.
- fdi  in  4  flash SIO input data.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - Outputs: fcen=1, fsclk=0, fdoe=0, fdo=4'b1100, gnt0/1=0, rvalid0/1=0, busy=0, rdata=0.
  - State goes to IDLE; the round-robin pointer is cleared to port 0.
- States: IDLE → CMD → ADDR → MODE → DUMMY → DATA → RECOV → IDLE.
- IDLE: if any req is high, pulse gntN for 1 cycle in the same cycle, latch addrN with bits [1:0] forced to 0, and latch the port ID.
- Arbitration: fixed priority, port 0 wins on simultaneous requests.
- SCLK: fsclk toggles every HCLK in CMD through DATA (period = 2 HCLK). fdo/fdoe change only while fsclk is low; fdi is sampled on the HCLK edge that drives fsclk 0→1.
- Cycle timing, with grant at cycle T:
  - T+1: fcen=0.
  - T+2: first rising fsclk.
  - Total rising edges N = 8+6+2+DUMMY_CLKS+8 (28 at defaults); the last one is at T+2N.
  - T+2N+1: fsclk=0.
  - T+2N+2: fcen=1, rvalidN=1, rdata updated.
- CMD: 8 SCLKs, fdoe=1, fdo={2'b11, 1'b0, cmd_bit}, command 0xEB sent MSB first.
- ADDR: 6 SCLKs, fdoe=1, fdo = address nibble, MSB nibble first.
- MODE: 2 SCLKs, fdoe=1, fdo = MODE_BYTE high nibble, then low nibble.
- DUMMY: DUMMY_CLKS SCLKs, fdoe=0.
- DATA: 8 SCLKs, fdoe=0.
  - Nibbles arrive high nibble first within each byte; byte k lands in rdata[8k+7:8k] (little-endian).
  - rdata holds its value until the next rvalid.
- RECOV: fcen=1 for CS_HIGH_CLKS cycles, busy stays 1, no grant; then return to IDLE.
- Requests arriving while busy wait. A grant is first possible in the cycle IDLE is re-entered.
- A req dropped before its grant is ignored. A req dropped after its grant does not abort the transaction: rvalid still pulses.
- Counters: a bit/nibble counter of ceil(log2(max(8, DUMMY_CLKS))) bits, reloaded on each state entry.

Optional Feature:
- Macro: FLASH_ARB_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, the port not granted last wins; the pointer updates on every grant.
- Undefined: fixed priority, port 0 always wins. Port 1 may starve, which is acceptable for fetch-dominated traffic.

Test Plan:
- Single read: flash word at 0x000100 = bytes 11 22 33 44; req0 with addr0=0x000103 → gnt0 at T; the command is 0xEB on SIO0; address nibbles 0,0,0,1,0,0; rvalid0 at T+58 with rdata=0x44332211.
- Contention: req0 and req1 rise in the same cycle → gnt0 first. gnt1 comes exactly 58+2 cycles after gnt0 (58-cycle transaction plus CS_HIGH_CLKS recovery, re-entry to IDLE at gnt0+60). rvalid1 returns port-1 data.
- RR (FLASH_ARB_RR_EN): four back-to-back simultaneous requests → grants alternate 0,1,0,1. Without the macro: 0,0,0,0 while req0 stays high.
- Reset mid-DATA: assert wb_rst_i at T+50 → fcen=1, fsclk=0, fdoe=0 in the same cycle, and no rvalid. A new req0 after release completes normally.
- Pin protocol: check fdoe=0 from the first DUMMY falling edge through DATA. Check fdo is stable across every fsclk rising edge. Check fcen stays high for ≥2 HCLK between back-to-back transactions.
- Timing sweep: DUMMY_CLKS=6 → rvalid at T+2*30+2 = T+62.
